// File: rtl/id_operand_stage_pkg.sv
// Shared definitions for the decode/operand-fetch stage: widths, RV32I opcodes
// and the instruction field slicer.
package id_operand_stage_pkg;

  localparam int unsigned XLEN_DEF = 32;
  localparam int unsigned NREG_DEF = 32;
  localparam int unsigned REG_AW   = 5;
  localparam int unsigned ILEN     = 32;
  localparam int unsigned OPC_W    = 7;

  localparam logic [OPC_W-1:0] OPC_LUI    = 7'b0110111;
  localparam logic [OPC_W-1:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [OPC_W-1:0] OPC_JAL    = 7'b1101111;
  localparam logic [OPC_W-1:0] OPC_JALR   = 7'b1100111;
  localparam logic [OPC_W-1:0] OPC_BRANCH = 7'b1100011;
  localparam logic [OPC_W-1:0] OPC_LOAD   = 7'b0000011;
  localparam logic [OPC_W-1:0] OPC_STORE  = 7'b0100011;
  localparam logic [OPC_W-1:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [OPC_W-1:0] OPC_OP     = 7'b0110011;
  localparam logic [OPC_W-1:0] OPC_SYSTEM = 7'b1110011;

  typedef struct packed {
    logic [OPC_W-1:0]  opcode;
    logic [REG_AW-1:0] rd;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
  } inst_fields_t;

  // Register-index and opcode fields share fixed positions across all RV32I formats.
  function automatic inst_fields_t f_fields(input logic [ILEN-1:0] inst);
    inst_fields_t f;
    f.opcode = inst[6:0];
    f.rd     = inst[11:7];
    f.rs1    = inst[19:15];
    f.rs2    = inst[24:20];
    return f;
  endfunction

endpackage

// File: rtl/id_scoreboard.sv
// One busy bit per architectural register; x0 never busy. Set wins over any
// same-cycle clear of the same index.
module id_scoreboard
  import id_operand_stage_pkg::*;
#(
  parameter int unsigned NREG = NREG_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              set_en_i,
  input  logic [REG_AW-1:0] set_idx_i,
  input  logic              clr_en_i,
  input  logic [REG_AW-1:0] clr_idx_i,
  input  logic              fl_en_i,
  input  logic [REG_AW-1:0] fl_idx_i,
  input  logic [REG_AW-1:0] chk_a_idx_i,
  input  logic [REG_AW-1:0] chk_b_idx_i,
  input  logic [REG_AW-1:0] chk_d_idx_i,
  output logic              busy_a_c,
  output logic              busy_b_c,
  output logic              busy_d_c
);

  logic [NREG-1:0] busy_q, busy_d;

  always_comb begin
    busy_d = busy_q;
    if (clr_en_i) busy_d[clr_idx_i] = 1'b0;
    if (fl_en_i)  busy_d[fl_idx_i]  = 1'b0;
    if (set_en_i) busy_d[set_idx_i] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  // Registered state only: a same-cycle writeback is not bypassed.
  assign busy_a_c = busy_q[chk_a_idx_i];
  assign busy_b_c = busy_q[chk_b_idx_i];
  assign busy_d_c = busy_q[chk_d_idx_i];

endmodule

// File: rtl/id_operand_stage.sv
// Decode/operand-fetch stage: drives RF read addresses, stalls on scoreboard
// hazards and registers instruction plus operands for EX.
module id_operand_stage
  import id_operand_stage_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEF,
  parameter int unsigned NREG = NREG_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [XLEN-1:0]   in_pc,
  input  logic [ILEN-1:0]   in_inst,
  output logic [REG_AW-1:0] ra,
  output logic [REG_AW-1:0] rb,
  input  logic [XLEN-1:0]   ra_data,
  input  logic [XLEN-1:0]   rb_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_pc,
  output logic [ILEN-1:0]   out_inst,
  output logic [XLEN-1:0]   out_rs1_val,
  output logic [XLEN-1:0]   out_rs2_val,
  output logic [REG_AW-1:0] out_rd,
  output logic              out_rd_wen,
  input  logic              wb_valid,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              flush
);

  inst_fields_t      fld_c;
  logic              uses_rs1_c, uses_rs2_c, writes_rd_c;
  logic              busy_a_c, busy_b_c, busy_d_c;
  logic              hazard_c, accept_c;

  logic              out_valid_q, out_valid_d;
  logic [XLEN-1:0]   out_pc_q, out_pc_d;
  logic [ILEN-1:0]   out_inst_q, out_inst_d;
  logic [XLEN-1:0]   out_rs1_q, out_rs1_d;
  logic [XLEN-1:0]   out_rs2_q, out_rs2_d;
  logic [REG_AW-1:0] out_rd_q, out_rd_d;
  logic              out_rd_wen_q, out_rd_wen_d;

  assign fld_c = f_fields(in_inst);
  assign ra    = fld_c.rs1;
  assign rb    = fld_c.rs2;

  always_comb begin
    uses_rs1_c  = 1'b1;
    uses_rs2_c  = 1'b0;
    writes_rd_c = 1'b1;
    if (fld_c.opcode == OPC_LUI || fld_c.opcode == OPC_AUIPC || fld_c.opcode == OPC_JAL)
      uses_rs1_c = 1'b0;
    if (fld_c.opcode == OPC_OP || fld_c.opcode == OPC_STORE || fld_c.opcode == OPC_BRANCH)
      uses_rs2_c = 1'b1;
    if (fld_c.opcode == OPC_STORE || fld_c.opcode == OPC_BRANCH || fld_c.rd == '0)
      writes_rd_c = 1'b0;
  end

  assign hazard_c = (uses_rs1_c & busy_a_c) | (uses_rs2_c & busy_b_c) | (writes_rd_c & busy_d_c);
  assign in_ready = rst & (~out_valid_q | out_ready) & ~hazard_c & ~flush;
  assign accept_c = in_valid & in_ready;

  // A squashed instruction's write will never retire, so release its busy bit.
  id_scoreboard #(.NREG(NREG)) u_scoreboard (
    .clk         (clk),
    .rst_n       (rst),
    .set_en_i    (accept_c & writes_rd_c),
    .set_idx_i   (fld_c.rd),
    .clr_en_i    (wb_valid),
    .clr_idx_i   (wb_rd),
    .fl_en_i     (flush & out_valid_q & out_rd_wen_q),
    .fl_idx_i    (out_rd_q),
    .chk_a_idx_i (fld_c.rs1),
    .chk_b_idx_i (fld_c.rs2),
    .chk_d_idx_i (fld_c.rd),
    .busy_a_c    (busy_a_c),
    .busy_b_c    (busy_b_c),
    .busy_d_c    (busy_d_c)
  );

  always_comb begin
    out_valid_d  = out_valid_q;
    out_pc_d     = out_pc_q;
    out_inst_d   = out_inst_q;
    out_rs1_d    = out_rs1_q;
    out_rs2_d    = out_rs2_q;
    out_rd_d     = out_rd_q;
    out_rd_wen_d = out_rd_wen_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (accept_c) begin
      out_valid_d  = 1'b1;
      out_pc_d     = in_pc;
      out_inst_d   = in_inst;
      out_rs1_d    = ra_data;
      out_rs2_d    = rb_data;
      out_rd_d     = fld_c.rd;
      out_rd_wen_d = writes_rd_c;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_q  <= 1'b0;
      out_pc_q     <= '0;
      out_inst_q   <= '0;
      out_rs1_q    <= '0;
      out_rs2_q    <= '0;
      out_rd_q     <= '0;
      out_rd_wen_q <= 1'b0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_pc_q     <= out_pc_d;
      out_inst_q   <= out_inst_d;
      out_rs1_q    <= out_rs1_d;
      out_rs2_q    <= out_rs2_d;
      out_rd_q     <= out_rd_d;
      out_rd_wen_q <= out_rd_wen_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_pc      = out_pc_q;
  assign out_inst    = out_inst_q;
  assign out_rs1_val = out_rs1_q;
  assign out_rs2_val = out_rs2_q;
  assign out_rd      = out_rd_q;
  assign out_rd_wen  = out_rd_wen_q;

endmodule

// File: tb/tb_id_operand_stage.sv
// Directed bench for id_operand_stage; the bench models the register file and
// probes the scoreboard through in_ready.
module tb_id_operand_stage;

  logic        clk, rst;
  logic        in_valid, in_ready;
  logic [31:0] in_pc, in_inst;
  logic [4:0]  ra, rb;
  logic [31:0] ra_data, rb_data;
  logic        out_valid, out_ready;
  logic [31:0] out_pc, out_inst, out_rs1_val, out_rs2_val;
  logic [4:0]  out_rd;
  logic        out_rd_wen;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic        flush;

  logic [31:0] rf [32];
  int          n_checks, n_errors;

  assign ra_data = rf[ra];
  assign rb_data = rf[rb];

  id_operand_stage dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_inst(in_inst),
    .ra(ra), .rb(rb), .ra_data(ra_data), .rb_data(rb_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst),
    .out_rs1_val(out_rs1_val), .out_rs2_val(out_rs2_val), .out_rd(out_rd),
    .out_rd_wen(out_rd_wen), .wb_valid(wb_valid), .wb_rd(wb_rd), .flush(flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  localparam logic [31:0] ADDI_X1  = 32'h0050_0093; // addi x1,x0,5
  localparam logic [31:0] ADD_X2   = 32'h0010_8133; // add  x2,x1,x1
  localparam logic [31:0] ADDI_X3  = 32'h0070_0193; // addi x3,x0,7
  localparam logic [31:0] SW_X3    = 32'h0032_2423; // sw   x3,8(x4)
  localparam logic [31:0] BEQ_X5   = 32'h0062_8463; // beq  x5,x6,8
  localparam logic [31:0] LUI_X0   = 32'h0000_1037; // lui  x0,1
  localparam logic [31:0] ADDI_X9  = 32'h0004_0493; // addi x9,x8,0
  localparam logic [31:0] ADDI_X7  = 32'h0010_0393; // addi x7,x0,1
  localparam logic [31:0] ADDI_X10 = 32'h0003_8513; // addi x10,x7,0
  localparam logic [31:0] ADDI_X11 = 32'h0005_0593; // addi x11,x10,0
  localparam logic [31:0] ADDI_X12 = 32'h0004_8613; // addi x12,x9,0

  initial begin
    n_checks = 0; n_errors = 0;
    rst = 1'b0; in_valid = 1'b1; in_pc = '0; in_inst = ADDI_X1;
    out_ready = 1'b0; wb_valid = 1'b0; wb_rd = '0; flush = 1'b0;
    for (int i = 0; i < 32; i++) rf[i[4:0]] = 32'h100 + 32'(i);
    rf[0] = '0;

    #2;
    check("rst_in_ready",  64'(in_ready),   64'(0));
    check("rst_out_valid", 64'(out_valid),  64'(0));
    check("rst_out_pc",    64'(out_pc),     64'(0));
    check("rst_out_inst",  64'(out_inst),   64'(0));
    check("rst_out_rd",    64'(out_rd),     64'(0));
    check("rst_out_wen",   64'(out_rd_wen), 64'(0));
    check("rst_out_rs1",   64'(out_rs1_val),64'(0));
    tick(); tick();
    rst = 1'b1;

    // First instruction accepted straight out of reset
    in_pc = 32'h8000_0000; in_inst = ADDI_X1; out_ready = 1'b1; #1;
    check("t1_in_ready", 64'(in_ready), 64'(1));
    check("t1_ra",       64'(ra),       64'(0));
    check("t1_rb",       64'(rb),       64'(5));
    tick();
    check("t1_out_valid", 64'(out_valid),   64'(1));
    check("t1_out_rd",    64'(out_rd),      64'(1));
    check("t1_out_wen",   64'(out_rd_wen),  64'(1));
    check("t1_out_pc",    64'(out_pc),      64'(32'h8000_0000));
    check("t1_out_inst",  64'(out_inst),    64'(ADDI_X1));
    check("t1_out_rs1",   64'(out_rs1_val), 64'(0));

    // RAW on x1, released one cycle after writeback
    in_pc = 32'h8000_0004; in_inst = ADD_X2; #1;
    check("t2_raw_stall", 64'(in_ready), 64'(0));
    tick();
    check("t2_drained", 64'(out_valid), 64'(0));
    wb_valid = 1'b1; wb_rd = 5'd1; #1;
    check("t2_wb_no_bypass", 64'(in_ready), 64'(0));
    tick();
    rf[1] = 32'd5; wb_valid = 1'b0; #1;
    check("t2_released", 64'(in_ready), 64'(1));
    tick();
    check("t2_out_valid", 64'(out_valid),   64'(1));
    check("t2_out_rs1",   64'(out_rs1_val), 64'(5));
    check("t2_out_rs2",   64'(out_rs2_val), 64'(5));
    check("t2_out_rd",    64'(out_rd),      64'(2));
    check("t2_out_pc",    64'(out_pc),      64'(32'h8000_0004));

    // Back-pressure hold for three cycles; x2 retires meanwhile
    out_ready = 1'b0; in_pc = 32'h8000_0008; in_inst = ADDI_X3;
    wb_valid = 1'b1; wb_rd = 5'd2;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("t3_hold_ready", 64'(in_ready), 64'(0));
      tick();
      if (k == 0) begin rf[2] = 32'h0000_00AA; wb_valid = 1'b0; end
      check("t3_hold_valid", 64'(out_valid),   64'(1));
      check("t3_hold_inst",  64'(out_inst),    64'(ADD_X2));
      check("t3_hold_pc",    64'(out_pc),      64'(32'h8000_0004));
      check("t3_hold_rs1",   64'(out_rs1_val), 64'(5));
    end
    out_ready = 1'b1; #1;
    check("t3_release_ready", 64'(in_ready), 64'(1));
    tick();
    check("t3_next_inst", 64'(out_inst), 64'(ADDI_X3));
    check("t3_next_rd",   64'(out_rd),   64'(3));

    // Retire x3 with an idle input cycle
    in_valid = 1'b0; wb_valid = 1'b1; wb_rd = 5'd3;
    tick();
    rf[3] = 32'd7; wb_valid = 1'b0;
    check("t4_idle_valid", 64'(out_valid), 64'(0));

    // Store, branch and lui x0 do not write rd
    in_valid = 1'b1; in_pc = 32'h8000_000C; in_inst = SW_X3; #1;
    check("t4_sw_ready", 64'(in_ready), 64'(1));
    tick();
    check("t4_sw_wen", 64'(out_rd_wen),  64'(0));
    check("t4_sw_rs1", 64'(out_rs1_val), 64'(32'h104));
    check("t4_sw_rs2", 64'(out_rs2_val), 64'(7));
    in_pc = 32'h8000_0010; in_inst = BEQ_X5; #1;
    check("t4_beq_ready", 64'(in_ready), 64'(1));
    tick();
    check("t4_beq_wen", 64'(out_rd_wen),  64'(0));
    check("t4_beq_rs1", 64'(out_rs1_val), 64'(32'h105));
    check("t4_beq_rs2", 64'(out_rs2_val), 64'(32'h106));
    in_pc = 32'h8000_0014; in_inst = LUI_X0; #1;
    check("t4_lui_ready", 64'(in_ready), 64'(1));
    tick();
    check("t4_lui_wen", 64'(out_rd_wen), 64'(0));
    check("t4_lui_rd",  64'(out_rd),     64'(0));
    in_pc = 32'h8000_0018; in_inst = ADDI_X9; #1;
    check("t4_x8_not_busy", 64'(in_ready), 64'(1));
    tick();
    check("t4_x9_rd",  64'(out_rd),      64'(9));
    check("t4_x9_wen", 64'(out_rd_wen),  64'(1));
    check("t4_x9_rs1", 64'(out_rs1_val), 64'(32'h108));

    // Flush squashes the held addi x7 and releases its busy bit
    in_pc = 32'h8000_0020; in_inst = ADDI_X7; #1;
    check("t5_x7_ready", 64'(in_ready), 64'(1));
    tick();
    check("t5_x7_rd", 64'(out_rd), 64'(7));
    out_ready = 1'b0; in_pc = 32'h8000_0024; in_inst = ADDI_X10; #1;
    check("t5_x7_busy", 64'(in_ready), 64'(0));
    flush = 1'b1; #1;
    check("t5_flush_blocks", 64'(in_ready), 64'(0));
    tick();
    flush = 1'b0;
    check("t5_flush_valid", 64'(out_valid), 64'(0));
    #1;
    check("t5_x7_cleared", 64'(in_ready), 64'(1));
    tick();
    in_valid = 1'b0;
    check("t5_x10_valid", 64'(out_valid),   64'(1));
    check("t5_x10_rd",    64'(out_rd),      64'(10));
    check("t5_x10_rs1",   64'(out_rs1_val), 64'(32'h107));
    in_inst = ADDI_X11; flush = 1'b1; wb_valid = 1'b1; wb_rd = 5'd10;
    tick();
    flush = 1'b0; wb_valid = 1'b0;
    check("t5_flush2_valid", 64'(out_valid), 64'(0));
    #1;
    check("t5_x10_cleared", 64'(in_ready), 64'(1));
    in_inst = ADDI_X12; #1;
    check("t5_x9_busy_in_ex", 64'(in_ready), 64'(0));

    // Asynchronous reset in the middle of a stall
    out_ready = 1'b1; in_valid = 1'b1; in_pc = 32'h8000_0040; in_inst = ADDI_X1; #1;
    check("t6_x1_ready", 64'(in_ready), 64'(1));
    tick();
    check("t6_x1_valid", 64'(out_valid), 64'(1));
    out_ready = 1'b0; in_pc = 32'h8000_0044; in_inst = ADD_X2; #1;
    check("t6_stall", 64'(in_ready), 64'(0));
    #2 rst = 1'b0;
    #1;
    check("t6_rst_valid", 64'(out_valid),  64'(0));
    check("t6_rst_ready", 64'(in_ready),   64'(0));
    check("t6_rst_wen",   64'(out_rd_wen), 64'(0));
    check("t6_rst_pc",    64'(out_pc),     64'(0));
    tick();
    rst = 1'b1; out_ready = 1'b1; #1;
    check("t6_post_rst_ready", 64'(in_ready), 64'(1));
    tick();
    check("t6_post_valid", 64'(out_valid),   64'(1));
    check("t6_post_rs1",   64'(out_rs1_val), 64'(5));
    check("t6_post_rd",    64'(out_rd),      64'(2));
    in_valid = 1'b0; in_inst = ADDI_X12; #1;
    check("t6_x9_reset_clear", 64'(in_ready), 64'(1));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
